splitter: RTL and testbench



---
 rtl/mpeg_ps_pkg.sv | 40 ++++
 rtl/ps_start_code_det.sv | 44 ++++
 rtl/splitter.sv | 233 +++++++++++++++++++++++
 tb/tb_splitter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_ps_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mpeg_ps_pkg
// Description : Shared MPEG-1 program-stream definitions used by the splitter
//               and the joiner: parser state codes, start-code prefix, stream
//               IDs and timestamp field lengths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mpeg_ps_pkg;

    // Parser state codes. Numeric values are shared with the joiner so both
    // blocks agree on the video / misc split.
    typedef enum logic [7:0] {
        NON_PACK               = 8'd0,
        NON_VIDEO_SIZE0        = 8'd1,
        NON_VIDEO_SIZE1        = 8'd2,
        NON_VIDEO_STREAM       = 8'd3,
        VIDEO_SIZE0            = 8'd4,
        VIDEO_SIZE1            = 8'd5,
        VIDEO_MISC             = 8'd6,
        VIDEO_TIMESTAMP_HEADER = 8'd7,
        VIDEO_TIMESTAMP        = 8'd8,
        VIDEO_STREAM           = 8'd9
    } ps_state_t;

    localparam logic [23:0] c_start_prefix   = 24'h000001;
    localparam logic [23:0] c_header_idle    = 24'hFFFFFF;
    localparam logic [7:0]  c_id_pack        = 8'hBA;
    localparam logic [7:0]  c_id_end         = 8'hB9;
    localparam logic [3:0]  c_vid_id_nib     = 4'hE;

    // Bytes remaining after the first timestamp flag byte: PTS only (2x)
    // carries 4 more bytes, PTS+DTS (3x) carries 9 more bytes.
    localparam logic [3:0]  c_ts_len_pts     = 4'd4;
    localparam logic [3:0]  c_ts_len_pts_dts = 4'd9;

endpackage : mpeg_ps_pkg
`default_nettype wire

// File: rtl/ps_start_code_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps_start_code_det
// Description : Three-byte history shift register with start-code prefix
//               (00 00 01) match. The match reflects the three bytes seen
//               before the byte currently being consumed.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               shift_en          - consume strobe; shifts data_in in
//               clear             - with shift_en, reload the idle pattern
//                                   instead of shifting (end-code handling)
//               data_in[7:0]      - byte being consumed
//               prefix_match      - history equals the start-code prefix
// Revision    : 1.0 - initial release
// ============================================================================
module ps_start_code_det
    import mpeg_ps_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       clear,
    input  logic [7:0] data_in,
    output logic       prefix_match
);

    logic [23:0] r_header;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_header <= c_header_idle;
        end else if (shift_en) begin
            if (clear) begin
                r_header <= c_header_idle;
            end else begin
                r_header <= {r_header[15:0], data_in};
            end
        end
    end

    assign prefix_match = (r_header == c_start_prefix);

endmodule : ps_start_code_det
`default_nettype wire

// File: rtl/splitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : splitter
// Description : MPEG-1 program-stream demultiplexer front end. Video payload
//               bytes (stream IDs with the video upper nibble, after the PES
//               header, stuffing and timestamps) go to the video FIFO; every
//               other byte goes, unchanged and in order, to the misc FIFO.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               clk_en                - all state advances only when high
//               mpeg_in[7:0]          - input byte, valid cycle after mpeg_rd
//               mpeg_empty            - input FIFO empty
//               mpeg_rd               - input FIFO read strobe (combinational)
//               vid_afull, misc_afull - downstream FIFOs almost full
//               vid_out[7:0], vid_wr  - video payload byte and write strobe
//               misc_out[7:0], misc_wr- non-video byte and write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module splitter
    import mpeg_ps_pkg::*;
#(
    parameter logic [15:0] PACK_HDR_LEN = 16'h8,
    parameter logic [3:0]  VID_ID_NIB   = c_vid_id_nib
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] mpeg_in,
    input  logic       mpeg_empty,
    output logic       mpeg_rd,
    input  logic       vid_afull,
    input  logic       misc_afull,
    output logic [7:0] vid_out,
    output logic       vid_wr,
    output logic [7:0] misc_out,
    output logic       misc_wr
);

    ps_state_t   r_state;
    ps_state_t   w_state_next;
    logic        r_byte_valid;
    logic [15:0] r_packet_counter;
    logic [15:0] w_packet_counter_next;
    logic [3:0]  r_timestamp_counter;
    logic [3:0]  w_timestamp_counter_next;
    logic        w_consume;
    logic        w_prefix_match;
    logic        w_header_clear;
    logic        w_is_video;
    logic        w_pc_is_one;
    logic [15:0] w_pc_dec;
    logic [15:0] w_len_loaded;

    // Reads are only issued while both downstream FIFOs have room for the
    // up-to-two bytes already in flight.
    assign mpeg_rd   = ~rst & clk_en & ~mpeg_empty & ~vid_afull & ~misc_afull;
    assign w_consume = clk_en & r_byte_valid;

    assign w_is_video   = (r_state == VIDEO_STREAM);
    assign w_pc_is_one  = (r_packet_counter == 16'd1);
    assign w_pc_dec     = r_packet_counter - 16'd1;
    assign w_len_loaded = {r_packet_counter[15:8], mpeg_in};

    ps_start_code_det u_start_code_det (
        .clk          (clk),
        .rst          (rst),
        .shift_en     (w_consume),
        .clear        (w_header_clear),
        .data_in      (mpeg_in),
        .prefix_match (w_prefix_match)
    );

    // ------------------------------------------------------------------
    // Parser state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= NON_PACK;
            r_packet_counter    <= 16'd0;
            r_timestamp_counter <= 4'd0;
        end else if (w_consume) begin
            r_state             <= w_state_next;
            r_packet_counter    <= w_packet_counter_next;
            r_timestamp_counter <= w_timestamp_counter_next;
        end
    end

    // Data on mpeg_in is stable while clk_en is low because no read is
    // issued, so byte_valid simply holds across disabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_valid <= 1'b0;
        end else if (clk_en) begin
            r_byte_valid <= mpeg_rd;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, evaluated only for a consumed byte
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next             = r_state;
        w_packet_counter_next    = r_packet_counter;
        w_timestamp_counter_next = r_timestamp_counter;
        w_header_clear           = 1'b0;

        if (w_consume) begin
            case (r_state)
                NON_PACK: begin
                    w_packet_counter_next = w_pc_dec;
                    if (w_prefix_match) begin
                        if (mpeg_in[7:4] == VID_ID_NIB) begin
                            w_state_next = VIDEO_SIZE0;
                        end else if (mpeg_in == c_id_pack) begin
                            w_state_next          = NON_VIDEO_STREAM;
                            w_packet_counter_next = PACK_HDR_LEN;
                        end else if (mpeg_in == c_id_end) begin
                            // Forget the prefix so trailing bytes cannot
                            // combine with it into a false start code.
                            w_header_clear = 1'b1;
                        end else begin
                            w_state_next = NON_VIDEO_SIZE0;
                        end
                    end
                end

                NON_VIDEO_SIZE0: begin
                    w_packet_counter_next = {mpeg_in, r_packet_counter[7:0]};
                    w_state_next          = NON_VIDEO_SIZE1;
                end

                NON_VIDEO_SIZE1: begin
                    w_packet_counter_next = w_len_loaded;
                    w_state_next = (w_len_loaded == 16'd0) ? NON_PACK : NON_VIDEO_STREAM;
                end

                NON_VIDEO_STREAM: begin
                    w_packet_counter_next = w_pc_dec;
                    if (w_pc_is_one) begin
                        w_state_next = NON_PACK;
                    end
                end

                VIDEO_SIZE0: begin
                    w_packet_counter_next = {mpeg_in, r_packet_counter[7:0]};
                    w_state_next          = VIDEO_SIZE1;
                end

                VIDEO_SIZE1: begin
                    w_packet_counter_next = w_len_loaded;
                    w_state_next = (w_len_loaded == 16'd0) ? NON_PACK : VIDEO_TIMESTAMP_HEADER;
                end

                // Packet end takes priority in every video header state so a
                // header-only packet never emits video bytes.
                VIDEO_TIMESTAMP_HEADER: begin
                    w_packet_counter_next = w_pc_dec;
                    if (w_pc_is_one) begin
                        w_state_next = NON_PACK;
                    end else if (mpeg_in == 8'hFF) begin
                        w_state_next = VIDEO_TIMESTAMP_HEADER;
                    end else if (mpeg_in[7:6] == 2'b01) begin
                        w_state_next = VIDEO_MISC;
                    end else begin
                        case (mpeg_in[5:4])
                            2'b10: begin
                                w_state_next             = VIDEO_TIMESTAMP;
                                w_timestamp_counter_next = c_ts_len_pts;
                            end
                            2'b11: begin
                                w_state_next             = VIDEO_TIMESTAMP;
                                w_timestamp_counter_next = c_ts_len_pts_dts;
                            end
                            default: begin
                                w_state_next = VIDEO_STREAM;
                            end
                        endcase
                    end
                end

                VIDEO_MISC: begin
                    w_packet_counter_next = w_pc_dec;
                    w_state_next = w_pc_is_one ? NON_PACK : VIDEO_TIMESTAMP_HEADER;
                end

                VIDEO_TIMESTAMP: begin
                    w_packet_counter_next    = w_pc_dec;
                    w_timestamp_counter_next = r_timestamp_counter - 4'd1;
                    if (w_pc_is_one) begin
                        w_state_next = NON_PACK;
                    end else if (r_timestamp_counter == 4'd1) begin
                        w_state_next = VIDEO_STREAM;
                    end
                end

                VIDEO_STREAM: begin
                    w_packet_counter_next = w_pc_dec;
                    if (w_pc_is_one) begin
                        w_state_next = NON_PACK;
                    end
                end

                default: begin
                    w_state_next = NON_PACK;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers: exactly one single-cycle strobe per consumed byte
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_out  <= 8'd0;
            vid_wr   <= 1'b0;
            misc_out <= 8'd0;
            misc_wr  <= 1'b0;
        end else begin
            vid_wr  <= w_consume & w_is_video;
            misc_wr <= w_consume & ~w_is_video;
            if (w_consume) begin
                if (w_is_video) begin
                    vid_out <= mpeg_in;
                end else begin
                    misc_out <= mpeg_in;
                end
            end
        end
    end

endmodule : splitter
`default_nettype wire

// File: tb/tb_splitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_splitter
// Description : Self-checking bench for splitter. Byte streams with a
//               hand-written video mask are pushed through an input FIFO
//               model; captured video / misc bytes are compared against the
//               masked split of the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_splitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [7:0] mpeg_in;
    logic       mpeg_empty;
    logic       mpeg_rd;
    logic       vid_afull;
    logic       misc_afull;
    logic [7:0] vid_out;
    logic       vid_wr;
    logic [7:0] misc_out;
    logic       misc_wr;

    always #5 clk = ~clk;

    splitter dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .mpeg_in    (mpeg_in),
        .mpeg_empty (mpeg_empty),
        .mpeg_rd    (mpeg_rd),
        .vid_afull  (vid_afull),
        .misc_afull (misc_afull),
        .vid_out    (vid_out),
        .vid_wr     (vid_wr),
        .misc_out   (misc_out),
        .misc_wr    (misc_wr)
    );

    // Stream record: n bytes right-aligned in d (first byte leftmost),
    // bit i of m set when byte i is expected on the video output.
    typedef struct {
        int           n;
        logic [191:0] d;
        logic [23:0]  m;
    } vec_t;

    logic [7:0] src_q[$];
    logic [7:0] vid_q[$];
    logic [7:0] misc_q[$];
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[9];

    // Input FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mpeg_rd && src_q.size() > 0) begin
            mpeg_in <= src_q.pop_front();
        end
    end

    // Empty flag refresh and downstream capture, away from the active edge.
    always @(negedge clk) begin
        mpeg_empty = (src_q.size() == 0);
        if (vid_wr) vid_q.push_back(vid_out);
        if (misc_wr) misc_q.push_back(misc_out);
        if (vid_wr || misc_wr) begin
            checks++;
            if (vid_wr && misc_wr) begin
                errors++;
                $display("FAIL both_strobes: vid_wr=%0b misc_wr=%0b, required one only", vid_wr, misc_wr);
            end
        end
    end

    function automatic vec_t mk(input int n, input logic [191:0] d, input logic [23:0] m);
        vec_t v;
        v.n = n;
        v.d = d;
        v.m = m;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input vec_t v, input int i);
        return v.d[8*(v.n-1-i) +: 8];
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) src_q.push_back(byte_at(v, i));
        mpeg_empty = 1'b0;
    endtask

    task automatic drain(input bit toggle_en, input string tag);
        int cyc = 0;
        while (src_q.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            if (toggle_en) clk_en = ~clk_en;
            cyc++;
        end
        clk_en = 1'b1;
        repeat (6) @(negedge clk);
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d bytes left, required 0", tag, src_q.size());
        end
    endtask

    task automatic compare(input vec_t v, input string tag);
        logic [7:0] ev[$];
        logic [7:0] em[$];
        logic [7:0] act;
        for (int i = 0; i < v.n; i++) begin
            if (v.m[i]) ev.push_back(byte_at(v, i));
            else        em.push_back(byte_at(v, i));
        end
        check_val({tag, " vid_count"}, vid_q.size(), ev.size());
        check_val({tag, " misc_count"}, misc_q.size(), em.size());
        for (int i = 0; i < ev.size(); i++) begin
            act = (i < vid_q.size()) ? vid_q[i] : 8'hxx;
            check_val($sformatf("%s vid[%0d]", tag, i), {24'd0, act}, {24'd0, ev[i]});
        end
        for (int i = 0; i < em.size(); i++) begin
            act = (i < misc_q.size()) ? misc_q[i] : 8'hxx;
            check_val($sformatf("%s misc[%0d]", tag, i), {24'd0, act}, {24'd0, em[i]});
        end
        vid_q.delete();
        misc_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input bit toggle_en, input string tag);
        push_vec(v);
        drain(toggle_en, tag);
        compare(v, tag);
    endtask

    task automatic wait_vid(input int cnt, input string tag);
        int cyc = 0;
        while (vid_q.size() < cnt && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s wait_vid: actual %0d writes required %0d", tag, vid_q.size(), cnt);
        end
    endtask

    initial begin
        vec_t vbp;
        vec_t vrs;
        int   base;

        // Pack header: all misc
        vecs[0] = mk(12, 192'h000001BA4400040004010189, 24'h000000);
        // Video PES with stuffing and no timestamps
        vecs[1] = mk(14, 192'h000001E00008FFFF0FA1A2A3A4A5, 24'h003E00);
        // Video PES with PTS+DTS
        vecs[2] = mk(22, 192'h000001E000103111223344556677889_9B1B2B3B4B5B6, 24'h3F0000);
        // Zero-length audio PES, then short video PES
        vecs[3] = mk(16, 192'h000001C00000000001E000040FC1C2C3, 24'h00E000);
        // End code; following 01 E0 is not a start code
        vecs[4] = mk(9, 192'h000001B901E0000377, 24'h000000);
        // Garbage before the prefix, then one-byte payload
        vecs[5] = mk(10, 192'h1234000001E000020FD1, 24'h000200);
        // Header-only video packets
        vecs[6] = mk(15, 192'h000001E00002FFFF000001E000010F, 24'h000000);
        // Non-video PES
        vecs[7] = mk(9, 192'h000001C00003112233, 24'h000000);
        // Stuffing, STD-buffer field and PTS only
        vecs[8] = mk(15, 192'h000001E00009FF40122111223344E1, 24'h004000);

        vbp = mk(21, 192'h000001E0000F0F6162636465666768696A6B6C6D6E, 24'h1FFF80);
        vrs = mk(21, 192'h000001E0000F0F8182838485868788898A8B8C8D8E, 24'h1FFF80);

        rst        = 1'b1;
        clk_en     = 1'b1;
        mpeg_in    = 8'h00;
        mpeg_empty = 1'b1;
        vid_afull  = 1'b0;
        misc_afull = 1'b0;
        src_q.push_back(8'h55);
        mpeg_empty = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset vid_out", {24'd0, vid_out}, 32'd0);
        check_val("reset misc_out", {24'd0, misc_out}, 32'd0);
        check_val("reset vid_wr", {31'd0, vid_wr}, 32'd0);
        check_val("reset misc_wr", {31'd0, misc_wr}, 32'd0);
        check_val("reset mpeg_rd", {31'd0, mpeg_rd}, 32'd0);
        src_q.delete();
        mpeg_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Same streams with clk_en toggling every cycle
        run_vec(vecs[1], 1'b1, "clken_vec1");
        run_vec(vecs[2], 1'b1, "clken_vec2");

        // Backpressure mid-payload
        push_vec(vbp);
        wait_vid(4, "bp");
        vid_afull = 1'b1;
        #1;
        check_val("bp mpeg_rd_drop", {31'd0, mpeg_rd}, 32'd0);
        base = vid_q.size() + misc_q.size();
        repeat (20) @(negedge clk);
        #1;
        check_val("bp writes_after_afull_le2", {31'd0, (vid_q.size() + misc_q.size() - base) <= 2}, 32'd1);
        check_val("bp mpeg_rd_held", {31'd0, mpeg_rd}, 32'd0);
        vid_afull = 1'b0;
        drain(1'b0, "bp");
        compare(vbp, "bp");

        // Asynchronous reset in the middle of the payload
        push_vec(vrs);
        wait_vid(3, "rst");
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst vid_out", {24'd0, vid_out}, 32'd0);
        check_val("midrst vid_wr", {31'd0, vid_wr}, 32'd0);
        check_val("midrst misc_out", {24'd0, misc_out}, 32'd0);
        check_val("midrst misc_wr", {31'd0, misc_wr}, 32'd0);
        check_val("midrst mpeg_rd", {31'd0, mpeg_rd}, 32'd0);
        src_q.delete();
        mpeg_empty = 1'b1;
        @(negedge clk);
        vid_q.delete();
        misc_q.delete();
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], 1'b0, "post_rst_pack");
        run_vec(vecs[1], 1'b0, "post_rst_vid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_splitter
`default_nettype wire
